vadd_sum_collect: RTL and testbench

VADD_SUM_COLLECT -- requirements
Module: vadd_sum_collect

---
 rtl/vadd_sum_collect.sv | 141 ++++++++++++++
 tb/tb_vadd_sum_collect.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_sum_collect.sv
// rtl/vadd_sum_collect.sv - collects even/odd vadd partial sums and presents their registered total
module vadd_sum_collect #(
  parameter bit SUM_SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] sum_e,
  input  logic [63:0] sum_o,
  input  logic        sum_vld_e,
  input  logic        sum_vld_o,
  input  logic        sum_ovrflw_e,
  input  logic        res_ovrflw_e,
  input  logic        sum_ovrflw_o,
  input  logic        res_ovrflw_o,
  input  logic        rsp_invalid_fp_e,
  input  logic        rsp_tid_err_e,
  input  logic        rsp_invalid_fp_o,
  input  logic        rsp_tid_err_o,
  input  logic        total_ack,
  output logic [63:0] total,
  output logic        total_vld,
  output logic        total_ovrflw,
  output logic        unit_ovrflw,
  output logic        rsp_err,
  output logic        proto_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SUM  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_cap_e;
  logic        r_cap_o;
  logic [63:0] r_sum_e;
  logic [63:0] r_sum_o;
  logic [63:0] r_total;
  logic        r_total_ovrflw;
  logic        r_unit_ovrflw;
  logic        r_rsp_err;
  logic        r_proto_err;

  logic        w_take_e;
  logic        w_take_o;
  logic        w_begin;
  logic        w_err_in;
  logic        w_proto;
  logic [64:0] w_add;
  logic        w_ovf;

  // A sum is only accepted while waiting and only the first time per unit.
  assign w_take_e = sum_vld_e && (r_state == ST_WAIT) && !r_cap_e;
  assign w_take_o = sum_vld_o && (r_state == ST_WAIT) && !r_cap_o;
  assign w_begin  = (r_state == ST_IDLE) && start;
  assign w_err_in = rsp_invalid_fp_e | rsp_tid_err_e | rsp_invalid_fp_o | rsp_tid_err_o;

  // Any sum_vld that is not accepted is a protocol violation, as is a start outside IDLE.
  assign w_proto = (start && (r_state != ST_IDLE)) ||
                   (sum_vld_e && !w_take_e) ||
                   (sum_vld_o && !w_take_o);

  assign w_add = {1'b0, r_sum_e} + {1'b0, r_sum_o};
  assign w_ovf = SUM_SIGNED ? ((r_sum_e[63] == r_sum_o[63]) && (w_add[63] != r_sum_e[63]))
                            : w_add[64];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; WAIT exits on the edge where both captures are complete.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_WAIT;
      ST_WAIT: if ((r_cap_e || w_take_e) && (r_cap_o || w_take_o)) w_next = ST_SUM;
      ST_SUM:  w_next = ST_HOLD;
      ST_HOLD: if (total_ack) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture, accumulate flags and register the final add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_e        <= 1'b0;
      r_cap_o        <= 1'b0;
      r_sum_e        <= '0;
      r_sum_o        <= '0;
      r_total        <= '0;
      r_total_ovrflw <= 1'b0;
      r_unit_ovrflw  <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      if (w_begin) begin
        r_cap_e       <= 1'b0;
        r_cap_o       <= 1'b0;
        r_sum_e       <= '0;
        r_sum_o       <= '0;
        r_unit_ovrflw <= 1'b0;
        r_rsp_err     <= 1'b0;
      end else begin
        if (w_take_e) begin
          r_sum_e <= sum_e;
          r_cap_e <= 1'b1;
        end
        if (w_take_o) begin
          r_sum_o <= sum_o;
          r_cap_o <= 1'b1;
        end
        r_unit_ovrflw <= r_unit_ovrflw |
                         (w_take_e & (sum_ovrflw_e | res_ovrflw_e)) |
                         (w_take_o & (sum_ovrflw_o | res_ovrflw_o));
        if (r_state != ST_IDLE) r_rsp_err <= r_rsp_err | w_err_in;
      end
      if (r_state == ST_SUM) begin
        r_total        <= w_add[63:0];
        r_total_ovrflw <= w_ovf;
      end
      if (w_proto) r_proto_err <= 1'b1;
    end
  end

  assign total        = r_total;
  assign total_vld    = (r_state == ST_HOLD);
  assign total_ovrflw = r_total_ovrflw;
  assign unit_ovrflw  = r_unit_ovrflw;
  assign rsp_err      = r_rsp_err;
  assign proto_err    = r_proto_err;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vadd_sum_collect.sv
// tb/tb_vadd_sum_collect.sv - self-checking bench for vadd_sum_collect, signed and unsigned instances
module tb_vadd_sum_collect;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] sum_e = '0;
  logic [63:0] sum_o = '0;
  logic        sum_vld_e = 1'b0;
  logic        sum_vld_o = 1'b0;
  logic        sum_ovrflw_e = 1'b0;
  logic        res_ovrflw_e = 1'b0;
  logic        sum_ovrflw_o = 1'b0;
  logic        res_ovrflw_o = 1'b0;
  logic        rsp_invalid_fp_e = 1'b0;
  logic        rsp_tid_err_e = 1'b0;
  logic        rsp_invalid_fp_o = 1'b0;
  logic        rsp_tid_err_o = 1'b0;
  logic        total_ack = 1'b0;

  logic [63:0] s_total, u_total;
  logic        s_total_vld, u_total_vld;
  logic        s_total_ovrflw, u_total_ovrflw;
  logic        s_unit_ovrflw, u_unit_ovrflw;
  logic        s_rsp_err, u_rsp_err;
  logic        s_proto_err, u_proto_err;
  logic        s_busy, u_busy;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vadd_sum_collect #(.SUM_SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start),
    .sum_e(sum_e), .sum_o(sum_o), .sum_vld_e(sum_vld_e), .sum_vld_o(sum_vld_o),
    .sum_ovrflw_e(sum_ovrflw_e), .res_ovrflw_e(res_ovrflw_e),
    .sum_ovrflw_o(sum_ovrflw_o), .res_ovrflw_o(res_ovrflw_o),
    .rsp_invalid_fp_e(rsp_invalid_fp_e), .rsp_tid_err_e(rsp_tid_err_e),
    .rsp_invalid_fp_o(rsp_invalid_fp_o), .rsp_tid_err_o(rsp_tid_err_o),
    .total_ack(total_ack), .total(s_total), .total_vld(s_total_vld),
    .total_ovrflw(s_total_ovrflw), .unit_ovrflw(s_unit_ovrflw),
    .rsp_err(s_rsp_err), .proto_err(s_proto_err), .busy(s_busy)
  );

  vadd_sum_collect #(.SUM_SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start),
    .sum_e(sum_e), .sum_o(sum_o), .sum_vld_e(sum_vld_e), .sum_vld_o(sum_vld_o),
    .sum_ovrflw_e(sum_ovrflw_e), .res_ovrflw_e(res_ovrflw_e),
    .sum_ovrflw_o(sum_ovrflw_o), .res_ovrflw_o(res_ovrflw_o),
    .rsp_invalid_fp_e(rsp_invalid_fp_e), .rsp_tid_err_e(rsp_tid_err_e),
    .rsp_invalid_fp_o(rsp_invalid_fp_o), .rsp_tid_err_o(rsp_tid_err_o),
    .total_ack(total_ack), .total(u_total), .total_vld(u_total_vld),
    .total_ovrflw(u_total_ovrflw), .unit_ovrflw(u_unit_ovrflw),
    .rsp_err(u_rsp_err), .proto_err(u_proto_err), .busy(u_busy)
  );

  // Reference: true mathematical sum tested against the representable range.
  function automatic void ref_sum(input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] t, output logic ovf_s, output logic ovf_u);
    logic signed [65:0] sx;
    logic [64:0] ux;
    sx = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    ux = {1'b0, a} + {1'b0, b};
    t = ux[63:0];
    ovf_s = (sx > $signed({2'b00, 64'h7FFF_FFFF_FFFF_FFFF})) ||
            (sx < $signed({2'b11, 64'h8000_0000_0000_0000}));
    ovf_u = (ux > 65'h0_FFFF_FFFF_FFFF_FFFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_errs(input logic [3:0] v);
    {rsp_invalid_fp_e, rsp_tid_err_e, rsp_invalid_fp_o, rsp_tid_err_o} = v;
  endtask

  task automatic send_e(input logic [63:0] v, input logic f1, input logic f2);
    sum_e = v; sum_vld_e = 1'b1; sum_ovrflw_e = f1; res_ovrflw_e = f2;
  endtask

  task automatic send_o(input logic [63:0] v, input logic f1, input logic f2);
    sum_o = v; sum_vld_o = 1'b1; sum_ovrflw_o = f1; res_ovrflw_o = f2;
  endtask

  task automatic clear_vld();
    sum_vld_e = 1'b0; sum_vld_o = 1'b0;
    sum_ovrflw_e = 1'b0; res_ovrflw_e = 1'b0; sum_ovrflw_o = 1'b0; res_ovrflw_o = 1'b0;
    set_errs(4'b0000);
  endtask

  task automatic ack();
    total_ack = 1'b1;
    tick();
    total_ack = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({s_total, u_total} !== 128'd0) begin
      fails++; $display("FAIL reset_total: got %h/%h expected 0", s_total, u_total);
    end
    tests_run++;
    if ({s_total_vld, s_total_ovrflw, s_unit_ovrflw, s_rsp_err, s_proto_err, s_busy,
         u_total_vld, u_total_ovrflw, u_unit_ovrflw, u_rsp_err, u_proto_err, u_busy} !== 12'd0) begin
      fails++; $display("FAIL reset_flags: got %b%b%b%b%b%b expected 000000", s_total_vld,
                        s_total_ovrflw, s_unit_ovrflw, s_rsp_err, s_proto_err, s_busy);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_order();
    do_reset();
    pulse_start();
    tests_run++;
    if (s_busy !== 1'b1) begin fails++; $display("FAIL order_busy: got %b expected 1", s_busy); end
    tick(); tick();
    send_e(64'd5, 1'b0, 1'b0); tick(); clear_vld();
    tick(); tick();
    send_o(64'd7, 1'b0, 1'b0); tick(); clear_vld();
    tests_run++;
    if (s_total_vld !== 1'b0) begin fails++; $display("FAIL order_vld_early: got %b expected 0", s_total_vld); end
    tick();
    tests_run++;
    if (s_total_vld !== 1'b1 || s_total !== 64'd12) begin
      fails++; $display("FAIL order_total: got vld=%b %0d expected vld=1 12", s_total_vld, s_total);
    end
    tests_run++;
    if ({s_total_ovrflw, s_unit_ovrflw, s_rsp_err, s_proto_err} !== 4'b0000) begin
      fails++; $display("FAIL order_flags: got %b%b%b%b expected 0000", s_total_ovrflw,
                        s_unit_ovrflw, s_rsp_err, s_proto_err);
    end
    ack();
    tests_run++;
    if (s_busy !== 1'b0 || s_total_vld !== 1'b0 || s_total !== 64'd12) begin
      fails++; $display("FAIL order_after_ack: got busy=%b vld=%b total=%0d expected 0 0 12",
                        s_busy, s_total_vld, s_total);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse_start();
    send_e(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send_o(64'd1, 1'b0, 1'b0);
    tick(); clear_vld();
    tick();
    tests_run++;
    if (s_total_vld !== 1'b1 || s_total !== 64'h8000_0000_0000_0000 || s_total_ovrflw !== 1'b1) begin
      fails++; $display("FAIL simul_signed: got vld=%b %h ovf=%b expected 1 8000000000000000 1",
                        s_total_vld, s_total, s_total_ovrflw);
    end
    tests_run++;
    if (u_total_ovrflw !== 1'b0) begin
      fails++; $display("FAIL simul_unsigned_ovf: got %b expected 0", u_total_ovrflw);
    end
    ack();
  endtask

  task automatic test_unsigned();
    do_reset();
    pulse_start();
    send_e(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0); tick(); clear_vld();
    send_o(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1); tick(); clear_vld();
    tick();
    tests_run++;
    if (u_total !== 64'hFFFF_FFFF_FFFF_FFFE || u_total_ovrflw !== 1'b1) begin
      fails++; $display("FAIL unsigned_total: got %h ovf=%b expected fffffffffffffffe 1",
                        u_total, u_total_ovrflw);
    end
    tests_run++;
    if (s_total_ovrflw !== 1'b0 || u_unit_ovrflw !== 1'b1 || s_unit_ovrflw !== 1'b1) begin
      fails++; $display("FAIL unsigned_flags: got sovf=%b unit=%b/%b expected 0 1 1",
                        s_total_ovrflw, u_unit_ovrflw, s_unit_ovrflw);
    end
    ack();
  endtask

  task automatic test_protocol();
    do_reset();
    send_e(64'd3, 1'b0, 1'b0); tick(); clear_vld();
    tests_run++;
    if (s_proto_err !== 1'b1 || s_busy !== 1'b0) begin
      fails++; $display("FAIL proto_idle_vld: got perr=%b busy=%b expected 1 0", s_proto_err, s_busy);
    end
    do_reset();
    pulse_start();
    send_e(64'd1, 1'b0, 1'b0); tick(); clear_vld();
    send_e(64'd9, 1'b1, 1'b1); tick(); clear_vld();
    send_o(64'd2, 1'b0, 1'b0); tick(); clear_vld();
    tick();
    tests_run++;
    if (s_total !== 64'd3 || s_proto_err !== 1'b1 || s_unit_ovrflw !== 1'b0) begin
      fails++; $display("FAIL proto_dup: got %0d perr=%b unit=%b expected 3 1 0",
                        s_total, s_proto_err, s_unit_ovrflw);
    end
    ack();
    do_reset();
    pulse_start();
    send_e(64'd10, 1'b0, 1'b0); send_o(64'd20, 1'b0, 1'b0); tick(); clear_vld();
    tick();
    pulse_start();
    send_e(64'd99, 1'b0, 1'b0); tick(); clear_vld();
    tests_run++;
    if (s_total_vld !== 1'b1 || s_total !== 64'd30 || s_proto_err !== 1'b1) begin
      fails++; $display("FAIL proto_hold: got vld=%b %0d perr=%b expected 1 30 1",
                        s_total_vld, s_total, s_proto_err);
    end
    ack();
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, t;
    logic os, ou;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    ref_sum(a, b, t, os, ou);
    do_reset();
    pulse_start();
    set_errs(4'b0001); tick(); clear_vld();
    send_e(a, 1'b0, 1'b0); send_o(b, 1'b0, 1'b0); tick(); clear_vld();
    tick();
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (s_total_vld !== 1'b1 || s_total !== t || s_total_ovrflw !== os || s_rsp_err !== 1'b1) begin
        fails++; $display("FAIL bp_stable[%0d]: got vld=%b %h ovf=%b rerr=%b expected 1 %h %b 1",
                          i, s_total_vld, s_total, s_total_ovrflw, s_rsp_err, t, os);
      end
      tick();
    end
    ack();
    tests_run++;
    if (s_rsp_err !== 1'b1 || s_busy !== 1'b0) begin
      fails++; $display("FAIL bp_rsp_err_idle: got rerr=%b busy=%b expected 1 0", s_rsp_err, s_busy);
    end
    pulse_start();
    tests_run++;
    if (s_rsp_err !== 1'b0) begin fails++; $display("FAIL bp_rsp_err_clear: got %b expected 0", s_rsp_err); end
    do_reset();
  endtask

  task automatic test_midreset();
    do_reset();
    pulse_start();
    send_e(64'd123, 1'b1, 1'b0); tick(); clear_vld();
    reset = 1'b1;
    #1;
    tests_run++;
    if (s_total !== 64'd0 || {s_total_vld, s_total_ovrflw, s_unit_ovrflw, s_rsp_err, s_proto_err, s_busy} !== 6'd0) begin
      fails++; $display("FAIL midreset_outputs: got %h %b%b%b%b%b%b expected 0 000000", s_total,
                        s_total_vld, s_total_ovrflw, s_unit_ovrflw, s_rsp_err, s_proto_err, s_busy);
    end
    #1 reset = 1'b0;
    tick();
    pulse_start();
    send_o(64'd4, 1'b0, 1'b0); tick(); clear_vld();
    send_e(64'd4, 1'b0, 1'b0); tick(); clear_vld();
    tick();
    tests_run++;
    if (s_total_vld !== 1'b1 || s_total !== 64'd8 || s_unit_ovrflw !== 1'b0) begin
      fails++; $display("FAIL midreset_fresh: got vld=%b %0d unit=%b expected 1 8 0",
                        s_total_vld, s_total, s_unit_ovrflw);
    end
    ack();
  endtask

  task automatic test_random();
    logic [63:0] a, b, t;
    logic os, ou, fes, fer, fos, forr, exp_unit, exp_rerr;
    int order, gap, err_sel, hold;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[63:62] = b[63:62];
      ref_sum(a, b, t, os, ou);
      fes = 1'($urandom_range(0, 3) == 0); fer = 1'($urandom_range(0, 3) == 0);
      fos = 1'($urandom_range(0, 3) == 0); forr = 1'($urandom_range(0, 3) == 0);
      exp_unit = fes | fer | fos | forr;
      err_sel = $urandom_range(0, 5);
      exp_rerr = (err_sel < 4);
      order = $urandom_range(0, 2);
      gap = $urandom_range(0, 3);
      pulse_start();
      repeat (gap) tick();
      if (exp_rerr) set_errs(4'b0001 << err_sel);
      if (order == 0) begin
        send_e(a, fes, fer); send_o(b, fos, forr);
        tick(); clear_vld();
      end else begin
        if (order == 1) send_e(a, fes, fer); else send_o(b, fos, forr);
        tick(); clear_vld();
        repeat ($urandom_range(0, 3)) tick();
        if (order == 1) send_o(b, fos, forr); else send_e(a, fes, fer);
        tick(); clear_vld();
      end
      tests_run++;
      if (s_total_vld !== 1'b0 || s_busy !== 1'b1) begin
        fails++; $display("FAIL rnd_sum_cycle[%0d]: got vld=%b busy=%b expected 0 1", n, s_total_vld, s_busy);
      end
      tick();
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        tests_run++;
        if (s_total_vld !== 1'b1 || s_total !== t || u_total !== t ||
            s_total_ovrflw !== os || u_total_ovrflw !== ou) begin
          fails++; $display("FAIL rnd_total[%0d]: got vld=%b %h/%h ovf=%b/%b expected 1 %h %b/%b",
                            n, s_total_vld, s_total, u_total, s_total_ovrflw, u_total_ovrflw, t, os, ou);
        end
        tests_run++;
        if (s_unit_ovrflw !== exp_unit || s_rsp_err !== exp_rerr || s_proto_err !== 1'b0) begin
          fails++; $display("FAIL rnd_flags[%0d]: got unit=%b rerr=%b perr=%b expected %b %b 0",
                            n, s_unit_ovrflw, s_rsp_err, s_proto_err, exp_unit, exp_rerr);
        end
        if (h < hold - 1) tick();
      end
      ack();
      tests_run++;
      if (s_busy !== 1'b0 || s_total_vld !== 1'b0 || s_total !== t) begin
        fails++; $display("FAIL rnd_idle[%0d]: got busy=%b vld=%b %h expected 0 0 %h",
                          n, s_busy, s_total_vld, s_total, t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_simultaneous();
    test_unsigned();
    test_protocol();
    test_backpressure();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
